// File: rtl/sync_fifo_if.sv
// Push/pop bundle between a producer/consumer and sync_fifo.
// master drives requests and write data; slave (the FIFO) returns data, flags and count.
interface sync_fifo_if #(
  parameter int DATA_SIZE = 32,
  parameter int ADDR_SIZE = 3
);
  logic                 flush;
  logic                 wpush;
  logic [DATA_SIZE-1:0] wdata;
  logic                 wfull;
  logic                 walmost_full;
  logic                 rpop;
  logic [DATA_SIZE-1:0] rdata;
  logic                 rempty;
  logic                 ralmost_empty;
  logic [ADDR_SIZE:0]   count;
  logic                 overflow;
  logic                 underflow;

  modport master (
    output flush, wpush, wdata, rpop,
    input  wfull, walmost_full, rdata, rempty,
    input  ralmost_empty, count, overflow, underflow
  );

  modport slave (
    input  flush, wpush, wdata, rpop,
    output wfull, walmost_full, rdata, rempty,
    output ralmost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with occupancy count, almost flags and sync flush.
// Ports: clk, rst (async, active-high), bus (sync_fifo_if.slave: push/pop/flags).
// Optional macro SYNC_FIFO_ERR_EN enables sticky overflow/underflow flags.
module sync_fifo #(
  parameter int DATA_SIZE = 32,
  parameter int ADDR_SIZE = 3,
  parameter int AFULL_TH  = 6,
  parameter int AEMPTY_TH = 2
) (
  input logic        clk,
  input logic        rst,
  sync_fifo_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_SIZE;
  localparam logic [ADDR_SIZE:0] DEPTH_C  = DEPTH[ADDR_SIZE:0];
  localparam logic [ADDR_SIZE:0] AFULL_C  = AFULL_TH[ADDR_SIZE:0];
  localparam logic [ADDR_SIZE:0] AEMPTY_C = AEMPTY_TH[ADDR_SIZE:0];
  localparam logic [ADDR_SIZE:0] ONE_C    = 1;

  logic [DATA_SIZE-1:0] mem_q [DEPTH];
  logic [ADDR_SIZE-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_SIZE-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_SIZE:0]   count_q, count_d;
  logic                 full, empty;
  logic                 push_ok, pop_ok;

  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);

  assign bus.wfull         = full;
  assign bus.rempty        = empty;
  assign bus.walmost_full  = (count_q >= AFULL_C);
  assign bus.ralmost_empty = (count_q <= AEMPTY_C);
  assign bus.count         = count_q;
  assign bus.rdata         = mem_q[rd_ptr_q];

  // A pop frees the slot a full-FIFO push needs in the same cycle.
  assign push_ok = bus.wpush & (~full | bus.rpop) & ~bus.flush;
  assign pop_ok  = bus.rpop & ~empty & ~bus.flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + ONE_C;
        2'b01:   count_d = count_q - ONE_C;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= bus.wdata;
  end

`ifdef SYNC_FIFO_ERR_EN
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;

  // Sticky until rst; flush does not clear them.
  always_comb begin
    ovf_d = ovf_q | (bus.wpush & full & ~bus.rpop & ~bus.flush);
    unf_d = unf_q | (bus.rpop & empty & ~bus.flush);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
`else
  assign bus.overflow  = 1'b0;
  assign bus.underflow = 1'b0;
`endif
endmodule
